tmul_acc_drain: RTL and testbench
=================================

Name: tmul_acc_drain

Overview:
- Downstream stage of the 8-lane 32-bit tile multiplier.
- Consumes the multiplier's 8 x 64-bit product vector each cycle and accumulates per lane over a K-loop, unsigned.
- On the final beat it drains the 8 lane accumulators serially, one lane per handshake, to the writeback path.
- Backpressures the multiplier side while draining.

Parameters:
LANES, 8, number of product lanes (power of two)
IN_W, 64, width of each product lane
ACC_W, 80, accumulator width per lane (ACC_W >= IN_W)
CNT_W, 16, width of beat counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  product vector valid
in_ready  output  1  block can accept a product vector
in_c  input  LANES*IN_W  packed products; lane i at [i*IN_W +: IN_W]
in_last  input  1  qualifies the final beat of a K-loop (sampled with in_valid)
out_valid  output  1  out_data holds a drained lane
out_ready  input  1  consumer accepts current lane
out_data  output  ACC_W  accumulated value of lane out_lane
out_lane  output  $clog2(LANES)  lane index being drained
out_last  output  1  high when out_lane == LANES-1
out_count  output  CNT_W  number of beats accumulated in this tile
out_ovf  output  1  sticky per-lane overflow flag for out_lane

Behaviour:
- Reset (rst=1 at posedge): state=ACCUM, all acc[i]=0, ovf[i]=0, cnt=0, lane=0.
- Reset values of outputs: out_valid=0, out_lane=0, out_last=0, out_count=0, out_ovf=0, out_data=0, in_ready=1.
- Reset mid-drain or mid-accumulation discards all partial state; no output handshake completes in a reset cycle.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - Accept a beat when in_valid & in_ready: acc[i] <= acc[i] + zero_ext(in_c lane i), for all i, in the same cycle.
  - cnt <= cnt+1, saturating at 2^CNT_W-1.
  - Carry out of ACC_W sets ovf[i]; sum wraps modulo 2^ACC_W unless the feature below is enabled.
  - Accepted beat with in_last=1: the beat is included in the sums, then state=DRAIN, lane=0.
  - in_last is ignored when in_valid=0.
- State DRAIN:
  - in_ready=0; in_valid is ignored and no input is consumed.
  - out_valid=1; out_data=acc[lane]; out_ovf=ovf[lane]; out_count=cnt.
  - All outputs are stable while out_ready=0.
  - On out_valid & out_ready: lane <= lane+1.
  - If out_last: clear acc, ovf and cnt; lane=0; state=ACCUM, so in_ready=1 on the next cycle.
- Latency: out_valid rises the cycle after the last beat is accepted.
- Minimum drain: LANES cycles.
- Minimum tile period: K + LANES cycles.
- out_data, out_ovf and out_last are muxed from registers; no combinational path from in_* to out_*.
- out_ready is a don't-care in ACCUM.
- A single-beat tile (in_last on the first beat) is legal: out_count=1.

Optional Feature:
- Macro: TMUL_ACC_SAT_EN.
- Defined: on per-lane carry out, acc[i] saturates to 2^ACC_W-1 and holds there for the rest of the tile; ovf[i] is set.
- Undefined: acc[i] wraps modulo 2^ACC_W; ovf[i] is still set sticky on any wrap.
- Handshake and timing are identical in both builds.

Test Plan:
1. Reset, then beat1 in_c lane i = i+1 and beat2 lane i = 10*(i+1) with in_last on beat2 -> out_valid next cycle; 8 drained values 11,22,...,88; out_lane 0..7; out_last only on lane 7; out_count=2; out_ovf=0.
2. Same tile with out_ready toggling 1,0,1,0 -> each lane held stable while out_ready=0; in_ready=0 throughout the drain; in_valid=1 beats offered during the drain are not accumulated (next tile restarts from 0).
3. Single beat, lane i = 2^63, in_last=1, ACC_W=64 -> non-SAT build: drain shows lanes = 2^63, ovf=0. Second tile of two such beats -> lanes=0 with ovf=1 (wrap); SAT build: lanes=2^64-1 with ovf=1.
4. Assert rst during the drain at lane 3 -> next cycle out_valid=0, in_ready=1; a new tile of one beat (lane i = 5) drains 5 on every lane with out_count=1.
5. Back-to-back: two tiles of 3 beats each (all lanes = 1), in_valid held high -> first drain shows 3 on every lane; in_ready returns the cycle after lane 7 is accepted; second drain also shows 3, proving accumulators cleared.
6. Count saturation with CNT_W=2: five beats of ones, last with in_last -> out_count=3, lanes=5.

Source files
------------

// File: rtl/tmul_acc_drain.sv
// Per-lane unsigned K-loop accumulator behind the 8-lane tile multiplier, draining lanes serially to writeback.
// Build option: define TMUL_ACC_SAT_EN to saturate lane accumulators on carry-out instead of wrapping.
module tmul_acc_drain #(
    parameter int LANES = 8,
    parameter int IN_W  = 64,
    parameter int ACC_W = 80,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*IN_W-1:0]    in_c,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data,
    output logic [$clog2(LANES)-1:0] out_lane,
    output logic                     out_last,
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_ovf
);
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t              state_reg, state_next;
    logic [LANE_W-1:0]   lane_reg, lane_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                accept;
    logic                clear_acc;
    logic                lane_is_last;

    logic [ACC_W-1:0]    acc_view [LANES];
    logic [LANES-1:0]    ovf_view;

    assign lane_is_last = (lane_reg == LANE_W'(LANES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ACCUM;
            lane_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            lane_reg  <= lane_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        lane_next  = lane_reg;
        cnt_next   = cnt_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        clear_acc  = 1'b0;
        case (state_reg)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    // Beat counter sticks at all-ones rather than wrapping.
                    if (cnt_reg != {CNT_W{1'b1}})
                        cnt_next = cnt_reg + CNT_W'(1);
                    if (in_last) begin
                        state_next = DRAIN;
                        lane_next  = '0;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (lane_is_last) begin
                        state_next = ACCUM;
                        lane_next  = '0;
                        cnt_next   = '0;
                        clear_acc  = 1'b1;
                    end else begin
                        lane_next = lane_reg + LANE_W'(1);
                    end
                end
            end
            default: begin
                state_next = ACCUM;
                lane_next  = '0;
                cnt_next   = '0;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [ACC_W-1:0] acc_reg;
            logic             ovf_reg;
            logic [ACC_W:0]   sum;
            logic             carry;

            // One extra bit on the adder exposes the carry-out for the overflow flag.
            assign sum   = {1'b0, acc_reg} + {{(ACC_W + 1 - IN_W){1'b0}}, in_c[gi*IN_W +: IN_W]};
            assign carry = sum[ACC_W];

            always_ff @(posedge clk) begin
                if (rst || clear_acc) begin
                    acc_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (accept) begin
`ifdef TMUL_ACC_SAT_EN
                    acc_reg <= carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
                    acc_reg <= sum[ACC_W-1:0];
`endif
                    ovf_reg <= ovf_reg | carry;
                end
            end

            assign acc_view[gi] = acc_reg;
            assign ovf_view[gi] = ovf_reg;
        end
    endgenerate

    // Drain outputs come straight from registers; they read as zero outside a drain.
    assign out_lane  = lane_reg;
    assign out_data  = (state_reg == DRAIN) ? acc_view[lane_reg] : '0;
    assign out_ovf   = (state_reg == DRAIN) && ovf_view[lane_reg];
    assign out_last  = (state_reg == DRAIN) && lane_is_last;
    assign out_count = (state_reg == DRAIN) ? cnt_reg : '0;

endmodule

// File: tb/tb_tmul_acc_drain.sv
// Directed plus randomized bench for tmul_acc_drain against an arithmetic per-lane sum model.
// Built with ACC_W=64 and CNT_W=2 so wrap and count saturation are reachable in a few beats.
module tb_tmul_acc_drain;
    localparam int LANES  = 8;
    localparam int IN_W   = 64;
    localparam int ACC_W  = 64;
    localparam int CNT_W  = 2;
    localparam int LANE_W = 3;
    localparam logic [127:0] ACC_MOD = 128'd1 << ACC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*IN_W-1:0] in_c;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_W-1:0]      out_data;
    logic [LANE_W-1:0]     out_lane;
    logic                  out_last;
    logic [CNT_W-1:0]      out_count;
    logic                  out_ovf;

    tmul_acc_drain #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_c(in_c), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_last(out_last), .out_count(out_count), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [127:0] m_acc [LANES];
    bit           m_ovf [LANES];
    int           m_cnt;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) begin
            m_acc[i] = '0;
            m_ovf[i] = 1'b0;
        end
        m_cnt = 0;
    endtask

    task automatic model_beat(input logic [LANES*IN_W-1:0] vec);
        logic [127:0] s;
        for (int i = 0; i < LANES; i++) begin
            s = m_acc[i] + {64'd0, vec[i*IN_W +: IN_W]};
            if (s >= ACC_MOD) begin
                m_ovf[i] = 1'b1;
`ifdef TMUL_ACC_SAT_EN
                s = ACC_MOD - 128'd1;
`else
                s = s - ACC_MOD;
`endif
            end
            m_acc[i] = s;
        end
        if (m_cnt < CNT_MAX) m_cnt++;
    endtask

    function automatic logic [LANES*IN_W-1:0] fill(input logic [63:0] v);
        logic [LANES*IN_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = v;
        return r;
    endfunction

    function automatic logic [LANES*IN_W-1:0] ramp(input int mult);
        logic [LANES*IN_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = 64'(mult * (i + 1));
        return r;
    endfunction

    function automatic logic [LANES*IN_W-1:0] rand_vec();
        logic [LANES*IN_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = {$urandom, $urandom};
        return r;
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic beat(input logic [LANES*IN_W-1:0] vec, input bit last);
        check("in_ready_accum", {127'd0, in_ready}, 128'd1);
        check("out_valid_accum", {127'd0, out_valid}, 128'd0);
        in_valid = 1'b1;
        in_c     = vec;
        in_last  = last;
        @(posedge clk);
        model_beat(vec);
        $display("beat last=%0d cnt=%0d", last, m_cnt);
        @(negedge clk);
    endtask

    task automatic idle();
        check("in_ready_idle", {127'd0, in_ready}, 128'd1);
        in_valid = 1'b0;
        in_last  = 1'($urandom);
        in_c     = rand_vec();
        @(posedge clk);
        @(negedge clk);
    endtask

    // mode 0: always ready, 1: toggle 1,0,1,0..., 2: random
    task automatic drain(input int mode, input bit offer, input int stop_lane);
        int l = 0;
        int waitc = 0;
        bit tog = 1'b0;
        bit rdy;
        while (l < stop_lane) begin
            check("out_valid", {127'd0, out_valid}, 128'd1);
            check("in_ready_drain", {127'd0, in_ready}, 128'd0);
            check("out_lane", {125'd0, out_lane}, 128'(l));
            check("out_data", {64'd0, out_data}, m_acc[l]);
            check("out_ovf", {127'd0, out_ovf}, {127'd0, m_ovf[l]});
            check("out_last", {127'd0, out_last}, 128'(l == LANES - 1));
            check("out_count", {126'd0, out_count}, 128'(m_cnt));
            tog = ~tog;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = tog;
                default: rdy = (waitc >= 4) ? 1'b1 : 1'($urandom);
            endcase
            out_ready = rdy;
            if (offer) begin
                in_valid = 1'b1;
                in_c     = rand_vec();
                in_last  = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            if (rdy) begin
                $display("drain lane=%0d data=%0h ovf=%0d", l, m_acc[l], m_ovf[l]);
                l++;
                waitc = 0;
            end else begin
                waitc++;
            end
            @(negedge clk);
        end
        if (stop_lane == LANES) begin
            model_reset();
            check("in_ready_after_drain", {127'd0, in_ready}, 128'd1);
            check("out_valid_after_drain", {127'd0, out_valid}, 128'd0);
            in_valid  = 1'b0;
            out_ready = 1'($urandom);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; in_valid = 1'b0; in_c = '0; in_last = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_out_lane", {125'd0, out_lane}, 128'd0);
        check("rst_out_last", {127'd0, out_last}, 128'd0);
        check("rst_out_count", {126'd0, out_count}, 128'd0);
        check("rst_out_ovf", {127'd0, out_ovf}, 128'd0);
        check("rst_out_data", {64'd0, out_data}, 128'd0);
        rst = 1'b0;

        // Two-beat ramp tile: expect 11,22,...,88 and count 2.
        beat(ramp(1), 1'b0);
        beat(ramp(10), 1'b1);
        check("t1_lane0", m_acc[0], 128'd11);
        drain(0, 1'b0, LANES);

        // Same tile with toggling ready and input offered during the drain.
        beat(ramp(1), 1'b0);
        beat(ramp(10), 1'b1);
        drain(1, 1'b1, LANES);
        beat(fill(64'd7), 1'b1);
        drain(0, 1'b0, LANES);

        // Top-bit products: one beat fits, two beats overflow.
        beat(fill(64'h8000_0000_0000_0000), 1'b1);
        drain(0, 1'b0, LANES);
        beat(fill(64'h8000_0000_0000_0000), 1'b0);
        beat(fill(64'h8000_0000_0000_0000), 1'b1);
        drain(2, 1'b0, LANES);

        // Reset in the middle of a drain.
        beat(rand_vec(), 1'b0);
        beat(rand_vec(), 1'b1);
        drain(0, 1'b0, 3);
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
        check("midrst_out_lane", {125'd0, out_lane}, 128'd0);
        beat(fill(64'd5), 1'b1);
        drain(0, 1'b0, LANES);

        // Back-to-back tiles with in_valid held high.
        for (int t = 0; t < 2; t++) begin
            beat(fill(64'd1), 1'b0);
            beat(fill(64'd1), 1'b0);
            beat(fill(64'd1), 1'b1);
            drain(0, 1'b1, LANES);
        end

        // Beat count saturates at 3 while sums keep growing.
        for (int b = 0; b < 5; b++) beat(fill(64'd1), b == 4);
        drain(0, 1'b0, LANES);

        // Randomized tiles with idle gaps and random backpressure.
        for (int t = 0; t < 8; t++) begin
            k = $urandom_range(1, 5);
            for (int b = 0; b < k; b++) begin
                if ($urandom_range(0, 2) == 0) idle();
                beat(rand_vec(), b == k - 1);
            end
            drain(2, 1'($urandom), LANES);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
